// File: rtl/kitt_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kitt_scan_pkg
// Brief    : Shared encodings for the multi-channel KITT scanner
//            (scan mode and bounce direction).
// Revision : 1.0 - initial release
// ============================================================================
package kitt_scan_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_CENTRE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/kitt_trail_ch.sv
`default_nettype none
// ============================================================================
// Module   : kitt_trail_ch
// Brief    : One LED channel. Holds the fading trail level and compares it
//            against the shared PWM counter. With KITT_GAMMA_EN defined the
//            level is squared before the compare; a head channel always
//            compares at full brightness.
// Revision : 1.0 - initial release
// ============================================================================
module kitt_trail_ch #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_tick,
    input  logic                i_clear,
    input  logic                i_head_nxt,
    input  logic                i_head_cur,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_raw_pwm
);

    localparam logic [PWM_BITS-1:0] c_max_lvl = '1;

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_cmp_lvl;

    // Trail level: a head reloads full brightness, a mode change wipes the
    // trail, otherwise the level halves on every scan step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else if (i_tick) begin
            if (i_head_nxt) begin
                r_level <= c_max_lvl;
            end else if (i_clear) begin
                r_level <= '0;
            end else begin
                r_level <= r_level >> 1;
            end
        end
    end

`ifdef KITT_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_sq;
    assign w_sq      = r_level * r_level;
    assign w_cmp_lvl = i_head_cur ? c_max_lvl : w_sq[2*PWM_BITS-1:PWM_BITS];
`else
    // The current-head flag only matters for the gamma curve.
    logic w_unused_head;
    assign w_unused_head = i_head_cur;
    assign w_cmp_lvl     = r_level;
`endif

    assign o_raw_pwm = (w_cmp_lvl > i_pwm_cnt);

endmodule
`default_nettype wire

// File: rtl/kitt_scan_multi.sv
`default_nettype none
// ============================================================================
// Module   : kitt_scan_multi
// Brief    : Parametrised KITT scanner: prescaled tick, four scan patterns
//            (bounce, wrap, centre-out, blink) and a per-LED PWM fading
//            trail. Optional gamma-corrected trail: define KITT_GAMMA_EN.
// Revision : 1.0 - initial release
// ============================================================================
module kitt_scan_multi
    import kitt_scan_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int PWM_BITS = 4,
    parameter int BASE_DIV = 1000000,
    parameter int DIV_W    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [1:0]       speed,
    input  logic [1:0]       mode,
    input  logic             oinv,
    input  logic             osel,
    output logic [N_LED-1:0] led_out,
    output logic [N_LED-1:0] pwm_out,
    output logic             tick_out
);

    localparam int                 c_pos_w     = $clog2(N_LED);
    localparam int                 c_half      = N_LED / 2;
    localparam logic [DIV_W-1:0]   c_base_div  = DIV_W'(BASE_DIV);
    localparam logic [c_pos_w-1:0] c_pos_last  = c_pos_w'(N_LED - 1);
    localparam logic [c_pos_w-1:0] c_pos_prev  = c_pos_w'(N_LED - 2);
    localparam logic [c_pos_w-1:0] c_half_last = c_pos_w'(c_half - 1);
    localparam logic [c_pos_w-1:0] c_half_pos  = c_pos_w'(c_half);

    logic [DIV_W-1:0]    r_cnt, w_cnt_nxt, w_period, w_last;
    logic [c_pos_w-1:0]  r_pos, w_pos_nxt;
    dir_t                r_dir, w_dir_nxt;
    mode_t               r_mode, w_mode_nxt, w_mode_in;
    logic                r_phase, w_phase_nxt;
    logic                w_tick, w_clear;
    logic [N_LED-1:0]    w_head_cur, w_head_nxt, w_raw_pwm;
    logic [PWM_BITS-1:0] r_pwm_cnt;

    // Head bitmap implied by a given scan state.
    function automatic logic [N_LED-1:0] f_heads(mode_t m, logic [c_pos_w-1:0] p, logic ph);
        logic [N_LED-1:0] h;
        h = '0;
        case (m)
            MODE_BOUNCE, MODE_WRAP: h[p] = 1'b1;
            MODE_CENTRE: begin
                h[c_half_last - p] = 1'b1;
                h[c_half_pos + p]  = 1'b1;
            end
            default: h = {N_LED{ph}};
        endcase
        return h;
    endfunction

    // A speed change can leave the count past the new terminal value, so
    // the compare is >= to fire on the very next cycle instead of wrapping.
    assign w_period  = c_base_div >> speed;
    assign w_last    = w_period - 1'b1;
    assign w_tick    = ena && (r_cnt >= w_last);
    assign w_mode_in = mode_t'(mode);

    // Next scan state: prescaler plus position/direction/phase stepping.
    always_comb begin
        w_cnt_nxt   = r_cnt + 1'b1;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_mode_nxt  = r_mode;
        w_phase_nxt = r_phase;
        w_clear     = 1'b0;
        if (!ena || w_tick) begin
            w_cnt_nxt = '0;
        end
        if (w_tick) begin
            if (w_mode_in != r_mode) begin
                w_mode_nxt  = w_mode_in;
                w_pos_nxt   = '0;
                w_dir_nxt   = DIR_UP;
                w_phase_nxt = 1'b0;
                w_clear     = 1'b1;
            end else begin
                case (r_mode)
                    MODE_BOUNCE: begin
                        if (r_dir == DIR_UP) begin
                            if (r_pos == c_pos_last) begin
                                w_dir_nxt = DIR_DOWN;
                                w_pos_nxt = c_pos_prev;
                            end else begin
                                w_pos_nxt = r_pos + 1'b1;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                w_dir_nxt = DIR_UP;
                                w_pos_nxt = c_pos_w'(1);
                            end else begin
                                w_pos_nxt = r_pos - 1'b1;
                            end
                        end
                    end
                    MODE_WRAP:   w_pos_nxt = (r_pos == c_pos_last) ? '0 : r_pos + 1'b1;
                    MODE_CENTRE: w_pos_nxt = (r_pos == c_half_last) ? '0 : r_pos + 1'b1;
                    default:     w_phase_nxt = ~r_phase;
                endcase
            end
        end
        w_head_cur = f_heads(r_mode, r_pos, r_phase);
        w_head_nxt = f_heads(w_mode_nxt, w_pos_nxt, w_phase_nxt);
    end

    // Scan state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pos   <= '0;
            r_dir   <= DIR_UP;
            r_mode  <= MODE_BOUNCE;
            r_phase <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
            r_dir   <= w_dir_nxt;
            r_mode  <= w_mode_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_ch
        kitt_trail_ch #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_tick     (w_tick),
            .i_clear    (w_clear),
            .i_head_nxt (w_head_nxt[gi]),
            .i_head_cur (w_head_cur[gi]),
            .i_pwm_cnt  (r_pwm_cnt),
            .o_raw_pwm  (w_raw_pwm[gi])
        );
    end

    // Free-running PWM counter and registered output bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            led_out   <= '0;
            pwm_out   <= '0;
            tick_out  <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            led_out   <= (osel ? w_raw_pwm : w_head_cur) ^ {N_LED{oinv}};
            pwm_out   <= w_raw_pwm ^ {N_LED{oinv}};
            tick_out  <= w_tick;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kitt_scan_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_kitt_scan_multi
// Brief    : Self-checking bench for kitt_scan_multi (N_LED=8, PWM_BITS=4,
//            BASE_DIV=8). A step-index model predicts every output cycle;
//            directed sections pin the model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kitt_scan_multi;

    localparam int N = 8;
    localparam int BDIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [1:0] mode = 2'd0;
    logic       oinv = 1'b0;
    logic       osel = 1'b0;
    logic [N-1:0] led_out, pwm_out;
    logic       tick_out;

    int n_err = 0;
    int n_chk = 0;

    kitt_scan_multi #(
        .N_LED    (N),
        .PWM_BITS (4),
        .BASE_DIV (BDIV),
        .DIV_W    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .speed    (speed),
        .mode     (mode),
        .oinv     (oinv),
        .osel     (osel),
        .led_out  (led_out),
        .pwm_out  (pwm_out),
        .tick_out (tick_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State is the step index k since the last mode capture; the pattern
    // position is derived from k arithmetically.
    int         m_cnt, m_k, m_pwm, m_mode;
    int         m_lvl[N];
    logic [N-1:0] e_led, e_pwm;
    logic       e_tick;
    bit         m_valid = 0;

    function automatic logic [N-1:0] heads(int md, int k);
        logic [N-1:0] h;
        int p;
        h = '0;
        case (md)
            0: begin p = k % (2*N-2); if (p >= N) p = 2*N-2-p; h[p] = 1'b1; end
            1: h[k % N] = 1'b1;
            2: begin p = k % (N/2); h[N/2-1-p] = 1'b1; h[N/2+p] = 1'b1; end
            default: h = (k % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
        endcase
        return h;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cnt = 0; m_k = 0; m_pwm = 0; m_mode = 0;
            for (int i = 0; i < N; i++) m_lvl[i] = 0;
            e_led = '0; e_pwm = '0; e_tick = 1'b0;
            m_valid = 1;
        end else if (m_valid) begin
            int p; bit tk; bit chg;
            logic [N-1:0] raw, hd;
            p  = BDIV >> speed;
            tk = ena && (m_cnt >= p - 1);
            for (int i = 0; i < N; i++) raw[i] = (m_lvl[i] > m_pwm);
            hd = heads(m_mode, m_k);
            e_led  = (osel ? raw : hd) ^ {N{oinv}};
            e_pwm  = raw ^ {N{oinv}};
            e_tick = tk;
            m_pwm  = (m_pwm + 1) % 16;
            if (!ena || tk) m_cnt = 0; else m_cnt++;
            if (tk) begin
                chg = (int'(mode) != m_mode);
                if (chg) begin m_mode = int'(mode); m_k = 0; end
                else m_k++;
                hd = heads(m_mode, m_k);
                for (int i = 0; i < N; i++)
                    m_lvl[i] = hd[i] ? 15 : (chg ? 0 : m_lvl[i] / 2);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("led_out",  32'(led_out),  32'(e_led));
            chk("pwm_out",  32'(pwm_out),  32'(e_pwm));
            chk("tick_out", 32'(tick_out), 32'(e_tick));
        end
    end

    // ---------------- directed helpers ----------------
    logic [N-1:0] q_exp[$];

    // Follow ntk ticks; check spacing (per>0) and, if queued, the led_out
    // value one cycle after each tick_out.
    task automatic track(input string nm, input int ntk, input int per);
        int cyc = 0;
        int last = -1;
        int seen = 0;
        bit grab = 0;
        while ((seen < ntk || grab) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (grab) begin
                if (q_exp.size() > 0) chk({nm, "_head"}, 32'(led_out), 32'(q_exp.pop_front()));
                grab = 0;
            end
            if (tick_out && seen < ntk) begin
                if (last >= 0 && per > 0) chk({nm, "_period"}, 32'(cyc - last), 32'(per));
                last = cyc;
                seen++;
                grab = 1;
            end
        end
        if (cyc >= 400) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: saw %0d ticks expected %0d", nm, seen, ntk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [N-1:0] held;
        int tog;
        logic [N-1:0] prev;

        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_pwm", 32'(pwm_out), 32'h0);
        chk("rst_tick", 32'(tick_out), 32'h0);
        #1 rst = 1'b0; ena = 1'b1;

        // Bounce: 1..7, 6..0, 1, each held one period of 8.
        q_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        track("bounce", 15, 8);

        // Switch to centre-out mid-period.
        repeat (2) @(negedge clk);
        #1 mode = 2'd2;
        track("centre_first", 1, 0);
        chk("centre_first_head", 32'(led_out), 32'h18);
        chk("centre_clear", 32'(pwm_out & 8'hE7), 32'h0);
        q_exp = '{8'h24, 8'h42, 8'h81, 8'h18};
        track("centre", 4, 8);

        // Fastest speed: tick every cycle.
        #1 speed = 2'd3;
        track("fast", 6, 1);

        // Back to speed 0, then switch to speed 2 with cnt at 5.
        #1 speed = 2'd0;
        track("s0", 2, 8);
        repeat (4) @(negedge clk);
        #1 speed = 2'd2;
        @(negedge clk);
        chk("speed_chg_tick", 32'(tick_out), 32'h1);
        track("s2", 3, 2);

        // Enable low for 40 cycles.
        #1 ena = 1'b0; speed = 2'd0;
        tog = 0; held = '0; prev = pwm_out;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("ena_low_tick", 32'(tick_out), 32'h0);
            if (i == 2) held = led_out;
            if (i > 2 && led_out !== held) chk("ena_low_head", 32'(led_out), 32'(held));
            if (pwm_out !== prev) tog++;
            prev = pwm_out;
        end
        chk("ena_low_pwm_toggles", 32'(tog > 0), 32'h1);
        #1 ena = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!tick_out && n < 100);
        chk("ena_first_tick", 32'(n), 32'd8);

        // Inverted blink.
        #1 mode = 2'd3; oinv = 1'b1;
        q_exp = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        track("blink", 4, 8);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        chk("arst_led", 32'(led_out), 32'h0);
        chk("arst_pwm", 32'(pwm_out), 32'h0);
        chk("arst_tick", 32'(tick_out), 32'h0);
        mode = 2'd0; oinv = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        q_exp = '{8'h02, 8'h04};
        track("restart", 2, 8);
        q_exp.delete();

        // Randomised operation against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(39) == 0) mode  = 2'($urandom_range(3));
            if ($urandom_range(59) == 0) speed = 2'($urandom_range(3));
            if ($urandom_range(29) == 0) osel  = ~osel;
            if ($urandom_range(29) == 0) oinv  = ~oinv;
            if (ena ? ($urandom_range(79) == 0) : ($urandom_range(9) == 0)) ena = ~ena;
            if ($urandom_range(599) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kitt_scan_multi.md
Name: kitt_scan_multi

Overview:
- Parametrised successor to the current 8-LED KITT scanner core.
- LED count, PWM depth and tick period are parameters; mode set grows to four patterns (bounce, wrap, centre-out, blink).
- Every LED carries a per-channel fading trail driven by its own PWM comparator.
- Sits behind the board-level input debouncer; drives the dedicated output bank and the bidirectional bank.

Parameters:
- N_LED, 8, number of LED channels; must be even and >= 4.
- PWM_BITS, 4, brightness/PWM resolution; MAX_LVL = 2^PWM_BITS-1.
- BASE_DIV, 1000000, clk cycles per tick at speed=0; must be >= 8.
- DIV_W, 20, prescaler counter width; must satisfy 2^DIV_W >= BASE_DIV.

Ports:
- clk  in  1  system clock (10 MHz nominal).
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  run enable, already debounced/synchronised upstream.
- speed  in  2  tick period = BASE_DIV >> speed (x1, x2, x4, x8 faster).
- mode  in  2  0 bounce, 1 wrap, 2 centre-out, 3 blink.
- oinv  in  1  invert led_out and pwm_out.
- osel  in  1  0: led_out = head bitmap; 1: led_out = pwm_out (before inversion).
- led_out  out  N_LED  LED drive.
- pwm_out  out  N_LED  per-channel PWM trail.
- tick_out  out  1  one-cycle pulse per scan step.

Behaviour:
- Reset: prescaler=0, pos=0, dir=up, mode_q=0, all levels=0, pwm_cnt=0, blink phase=0, led_out=0, pwm_out=0, tick_out=0.
- Prescaler:
  - cnt counts 0..P-1 with P = BASE_DIV>>speed; tick asserts when cnt==P-1, after which cnt returns to 0.
  - If speed changes mid-count so that cnt >= P-1, fire the tick at the next cycle.
  - ena=0: cnt forced to 0, no ticks, pos/levels frozen; PWM and outputs keep running.
- Mode capture:
  - mode is sampled only on tick.
  - If the sampled mode differs from mode_q: this tick loads mode_q, pos=0, dir=up, phase=0, levels all 0, and sets the new heads to MAX_LVL.
- Step rules (on tick, mode unchanged):
  - Bounce: pos steps in dir. Up at N_LED-1 flips to down and goes to N_LED-2; down at 0 flips to up and goes to 1. No double dwell at the ends. Head = {pos}.
  - Wrap: pos = (pos+1) mod N_LED. Head = {pos}.
  - Centre-out: pos = (pos+1) mod N_LED/2. Heads = {N_LED/2-1-pos, N_LED/2+pos}.
  - Blink: phase toggles. Heads = all LEDs when phase=1, none when phase=0.
- Trail:
  - On tick, each head level is set to MAX_LVL; every non-head level shifts right by 1 (15, 7, 3, 1, 0).
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter, incremented every clk.
  - raw_pwm[i] = (level[i] > pwm_cnt). MAX_LVL gives 15/16 duty; 0 gives off.
- Outputs:
  - All outputs are registered.
  - led_out <= (osel ? raw_pwm : head_bitmap) ^ {N_LED{oinv}}.
  - pwm_out <= raw_pwm ^ {N_LED{oinv}}.
  - tick_out <= tick.
- Latency:
  - tick combinational in cycle T; pos/levels update at the end of T.
  - led_out and pwm_out reflect the new state from cycle T+2. tick_out is high in T+1.
- Reset mid-operation: immediate return to the reset values above, regardless of tick or PWM phase.

Optional Feature:
- KITT_GAMMA_EN defined: raw_pwm compares gamma(level) against pwm_cnt.
  - gamma(x) = (x*x) >> PWM_BITS; MAX_LVL maps to MAX_LVL-1 minimum clamp of MAX_LVL for head.
  - Head channels always compare MAX_LVL.
- Undefined: linear compare as above; no multiplier is synthesised.

Decomposition:
- Package kitt_scan_pkg: mode encoding constants (MODE_BOUNCE=0, MODE_WRAP=1, MODE_CENTRE=2, MODE_BLINK=3) and direction constants DIR_UP/DIR_DOWN.
- Sub-module kitt_trail_ch: one level register plus PWM comparator (and gamma when enabled), instantiated N_LED times from a generate loop.
- Prescaler and position FSM stay in the top.

Test Plan (N_LED=8, PWM_BITS=4, BASE_DIV=8, speed=0 unless stated):
- Reset, ena=1, mode=0, osel=0, oinv=0 -> tick_out every 8 cycles; head sequence 0,1,...,7,6,...,0,1, each position held for exactly one tick period.
- Bounce run, observe level[] after the head leaves bit 4 -> bit 4 decays 15, 7, 3, 1, 0 on successive ticks. With osel=1, pwm_out[4] high-count per 16 cycles is 15, 7, 3, 1, 0.
- mode switched 0->2 mid-period -> at the next tick heads are {3,4}, all other levels 0; then {2,5}, {1,6}, {0,7}, {3,4}.
- speed=3 -> tick_out period 1 cycle. speed=0->2 change while cnt=5 -> tick on the next cycle, then period 2.
- ena dropped for 40 cycles -> no tick_out, head bitmap constant, pwm_out still toggling. ena raised -> first tick 8 cycles later.
- oinv=1, mode=3 -> led_out alternates 0x00 / 0xFF inverted per tick. rst asserted asynchronously mid-tick -> led_out=0x00 and pwm_out=0x00 in the same cycle, state restarts at pos 0.
